matching_encoder: RTL and testbench

// - Parallel CAM-style search: compare lookup_value against SLOTS packed entries, report hit and index.
// - Highest-index valid match wins. Used by tag/ID lookup logic (reservation tables, load/store queues).
// - Combinational result path plus a one-cycle registered copy for timing-relaxed consumers.

---
 rtl/matching_encoder.sv | 86 ++++++++
 tb/tb_matching_encoder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/matching_encoder.sv
// matching_encoder: CAM-style search of packed slots, highest-index valid match wins; comb + 1-cycle registered result.
// Optional macro MATCHING_ENCODER_MATCH_VEC_EN adds the per-slot hit vector port match_vector. Rev 1.0
`default_nettype none

module matching_encoder #(
  parameter int INDEX_WIDTH = 2,
  parameter int VALUE_WIDTH = 4
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic [(1<<INDEX_WIDTH)*VALUE_WIDTH-1:0] array_values,
  input  logic [(1<<INDEX_WIDTH)-1:0]             array_valids,
  input  logic [VALUE_WIDTH-1:0]                  lookup_value,
  output logic                                    lookup_match,
  output logic [INDEX_WIDTH-1:0]                  lookup_index,
  output logic                                    lookup_multi,
  output logic                                    lookup_match_q,
  output logic [INDEX_WIDTH-1:0]                  lookup_index_q,
  output logic                                    lookup_multi_q
`ifdef MATCHING_ENCODER_MATCH_VEC_EN
  ,
  output logic [(1<<INDEX_WIDTH)-1:0]             match_vector
`endif
);

  localparam int SLOTS = 1 << INDEX_WIDTH;

  logic [SLOTS-1:0]       w_hit;
  logic                   w_match;
  logic                   w_multi;
  logic [INDEX_WIDTH-1:0] w_index;

  logic                   r_match;
  logic                   r_multi;
  logic [INDEX_WIDTH-1:0] r_index;

  always_comb begin
    for (int i = 0; i < SLOTS; i++) begin
      w_hit[i] = array_valids[i] &&
                 (array_values[i*VALUE_WIDTH +: VALUE_WIDTH] == lookup_value);
    end
  end

  // Ascending scan: later hits overwrite earlier ones so the highest index wins;
  // a hit seen while one is already recorded flags a multiple match.
  always_comb begin
    w_match = 1'b0;
    w_multi = 1'b0;
    w_index = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (w_hit[i]) begin
        if (w_match) begin
          w_multi = 1'b1;
        end
        w_match = 1'b1;
        w_index = INDEX_WIDTH'(i);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_match <= 1'b0;
      r_multi <= 1'b0;
      r_index <= '0;
    end else begin
      r_match <= w_match;
      r_multi <= w_multi;
      r_index <= w_index;
    end
  end

  assign lookup_match   = w_match;
  assign lookup_index   = w_index;
  assign lookup_multi   = w_multi;
  assign lookup_match_q = r_match;
  assign lookup_index_q = r_index;
  assign lookup_multi_q = r_multi;

`ifdef MATCHING_ENCODER_MATCH_VEC_EN
  assign match_vector = w_hit;
`endif

endmodule

`default_nettype wire

// File: tb/tb_matching_encoder.sv
// tb_matching_encoder: directed + random check of matching_encoder against a search model. Rev 1.0
`default_nettype none

module tb_matching_encoder;

  localparam int IW = 2;
  localparam int VW = 4;
  localparam int S  = 1 << IW;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [S*VW-1:0]   array_values = '0;
  logic [S-1:0]      array_valids = '0;
  logic [VW-1:0]     lookup_value = '0;
  logic              lookup_match;
  logic [IW-1:0]     lookup_index;
  logic              lookup_multi;
  logic              lookup_match_q;
  logic [IW-1:0]     lookup_index_q;
  logic              lookup_multi_q;
`ifdef MATCHING_ENCODER_MATCH_VEC_EN
  logic [S-1:0]      match_vector;
`endif

  int total = 0;
  int bad   = 0;

  matching_encoder #(.INDEX_WIDTH(IW), .VALUE_WIDTH(VW)) dut (
    .clock          (clock),
    .reset          (reset),
    .array_values   (array_values),
    .array_valids   (array_valids),
    .lookup_value   (lookup_value),
    .lookup_match   (lookup_match),
    .lookup_index   (lookup_index),
    .lookup_multi   (lookup_multi),
    .lookup_match_q (lookup_match_q),
    .lookup_index_q (lookup_index_q),
    .lookup_multi_q (lookup_multi_q)
`ifdef MATCHING_ENCODER_MATCH_VEC_EN
    ,
    .match_vector   (match_vector)
`endif
  );

  always #5 clock = ~clock;

  // Reference: walk slots from the top down; first valid equal slot is the winner.
  function automatic void model(input logic [S*VW-1:0] vals, input logic [S-1:0] vld,
                                input logic [VW-1:0] lv, output logic m,
                                output logic [IW-1:0] idx, output logic mul,
                                output logic [S-1:0] vec);
    int count;
    count = 0;
    idx   = '0;
    vec   = '0;
    for (int i = S - 1; i >= 0; i--) begin
      if (vld[i] === 1'b1 && vals[i*VW +: VW] === lv) begin
        vec[i] = 1'b1;
        if (count == 0) idx = IW'(i);
        count = count + 1;
      end
    end
    m   = (count > 0);
    mul = (count >= 2);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", nm, got, exp, $time);
    end
  endtask

  // Expected registered outputs: what the model said at the last capture edge.
  logic          e_mq = 1'b0;
  logic [IW-1:0] e_iq = '0;
  logic          e_uq = 1'b0;
  logic [S-1:0]  e_vq;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      e_mq = 1'b0;
      e_iq = '0;
      e_uq = 1'b0;
    end else begin
      model(array_values, array_valids, lookup_value, e_mq, e_iq, e_uq, e_vq);
    end
  end

  always @(negedge clock) begin
    logic          m;
    logic [IW-1:0] idx;
    logic          mul;
    logic [S-1:0]  vec;
    model(array_values, array_valids, lookup_value, m, idx, mul, vec);
    chk("cmp_match", 32'(lookup_match), 32'(m));
    chk("cmp_index", 32'(lookup_index), 32'(idx));
    chk("cmp_multi", 32'(lookup_multi), 32'(mul));
`ifdef MATCHING_ENCODER_MATCH_VEC_EN
    chk("cmp_vec", 32'(match_vector), 32'(vec));
`endif
    chk("cmp_match_q", 32'(lookup_match_q), 32'(e_mq));
    chk("cmp_index_q", 32'(lookup_index_q), 32'(e_iq));
    chk("cmp_multi_q", 32'(lookup_multi_q), 32'(e_uq));
  end

  task automatic drive(input logic [S*VW-1:0] vals, input logic [S-1:0] vld,
                       input logic [VW-1:0] lv);
    @(posedge clock);
    #2;
    array_values = vals;
    array_valids = vld;
    lookup_value = lv;
    #1;
  endtask

  task automatic lit(input string nm, input logic m, input logic [IW-1:0] idx,
                     input logic mul);
    chk({nm, "_match"}, 32'(lookup_match), 32'(m));
    chk({nm, "_index"}, 32'(lookup_index), 32'(idx));
    chk({nm, "_multi"}, 32'(lookup_multi), 32'(mul));
  endtask

  localparam logic [S*VW-1:0] ARR1234 = {4'd1, 4'd2, 4'd3, 4'd4};

  initial begin
    #1 reset = 1'b1;
    #1;
    chk("rst_match_q", 32'(lookup_match_q), 32'd0);
    chk("rst_index_q", 32'(lookup_index_q), 32'd0);
    chk("rst_multi_q", 32'(lookup_multi_q), 32'd0);
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;

    drive(ARR1234, 4'b1111, 4'd4); lit("lk4", 1'b1, 2'd0, 1'b0);
    drive(ARR1234, 4'b1111, 4'd3); lit("lk3", 1'b1, 2'd1, 1'b0);
    drive(ARR1234, 4'b1111, 4'd2); lit("lk2", 1'b1, 2'd2, 1'b0);
    drive(ARR1234, 4'b1111, 4'd1); lit("lk1", 1'b1, 2'd3, 1'b0);
    drive(ARR1234, 4'b1111, 4'd0); lit("lk0", 1'b0, 2'd0, 1'b0);
    drive(ARR1234, 4'b0111, 4'd1); lit("inv3", 1'b0, 2'd0, 1'b0);
    drive({4'd5, 4'd5, 4'd5, 4'd5}, 4'b1011, 4'd5); lit("all5", 1'b1, 2'd3, 1'b1);
`ifdef MATCHING_ENCODER_MATCH_VEC_EN
    chk("all5_vec", 32'(match_vector), 32'h0000000b);
`endif
    drive({4'd5, 4'd5, 4'd9, 4'd5}, 4'b0101, 4'd5); lit("lo2", 1'b1, 2'd2, 1'b1);
    drive({4'd7, 4'd5, 4'd5, 4'd5}, 4'b1000, 4'd5); lit("neq", 1'b0, 2'd0, 1'b0);

    // Load a nonzero registered result, then reset asynchronously between edges.
    drive(ARR1234, 4'b1111, 4'd1);
    @(negedge clock);
    #1 reset = 1'b1;
    #1;
    chk("arst_match_q", 32'(lookup_match_q), 32'd0);
    chk("arst_index_q", 32'(lookup_index_q), 32'd0);
    lit("arst_comb", 1'b1, 2'd3, 1'b0);
    @(posedge clock);
    #1 chk("hold_match_q", 32'(lookup_match_q), 32'd0);
    @(negedge clock);
    #1;
    reset = 1'b0;
    lookup_value = 4'd3;
    #1;
    chk("rel_match_q0", 32'(lookup_match_q), 32'd0);
    chk("rel_index_q0", 32'(lookup_index_q), 32'd0);
    @(posedge clock);
    #1;
    chk("rel_match_q1", 32'(lookup_match_q), 32'd1);
    chk("rel_index_q1", 32'(lookup_index_q), 32'd1);
    chk("rel_multi_q1", 32'(lookup_multi_q), 32'd0);

    for (int n = 0; n < 1000; n++) begin
      logic [S*VW-1:0] v;
      for (int i = 0; i < S; i++) v[i*VW +: VW] = VW'($urandom_range(0, (n < 500) ? 3 : 15));
      drive(v, S'($urandom), VW'($urandom_range(0, (n < 500) ? 3 : 15)));
    end
    @(negedge clock);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
